// File: rtl/booth_mult_seq_if.sv
// Handshake/operand bundle for booth_mult_seq.
// master: the requester driving operands and start; slave: the multiplier.
interface booth_mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     p;

    modport master (
        output start, is_signed, multiplicand, multiplier,
        input  busy, done, p
    );

    modport slave (
        input  start, is_signed, multiplicand, multiplier,
        output busy, done, p
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier, WIDTH-bit operands, signed or unsigned per request.
// Operands are extended to E = WIDTH+2 bits so one Booth datapath covers both
// modes; the product is the low 2*WIDTH bits of {A,Q} after ITER steps.
// Build option: define BOOTH_RADIX4_EN for radix-4 recoding (ITER = E/2),
// otherwise radix-2 (ITER = E). Ports and results are the same in both builds.
//
// state   | meaning
// IDLE    | waiting for start; product register holds the last result
// RUN     | one Booth step per cycle, busy=1
// DONE    | one-cycle done pulse; a start here is accepted back-to-back
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    booth_mult_seq_if.slave   bus
);
    localparam int E    = WIDTH + 2;
`ifdef BOOTH_RADIX4_EN
    localparam int ITER = E / 2;
`else
    localparam int ITER = E;
`endif
    localparam int CW   = $clog2(ITER);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [E-1:0]       r_a;
    logic [E-1:0]       r_q;
    logic               r_q1;
    logic [E-1:0]       r_m;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;

    logic               w_load;
    logic               w_last;
    logic               w_busy;
    logic               w_done;
    logic [E-1:0]       w_m_ext;
    logic [E-1:0]       w_q_ext;
    logic [E-1:0]       w_a_nxt;
    logic [E-1:0]       w_q_nxt;
    logic               w_q1_nxt;

    // Sign- or zero-extend the incoming operands to the internal width.
    always_comb begin
        w_m_ext = {{2{bus.is_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
        w_q_ext = {{2{bus.is_signed & bus.multiplier[WIDTH-1]}}, bus.multiplier};
    end

`ifdef BOOTH_RADIX4_EN
    logic [E:0] w_m1;
    logic [E:0] w_m2;
    logic [E:0] w_add;
    logic [E:0] w_sum;

    // Radix-4 step: add 0/+-M/+-2M in E+1 bits, then shift {A,Q,Q_1} right by 2.
    always_comb begin
        w_m1 = {r_m[E-1], r_m};
        w_m2 = {r_m, 1'b0};
        case ({r_q[1:0], r_q1})
            3'b001, 3'b010: w_add = w_m1;
            3'b011:         w_add = w_m2;
            3'b100:         w_add = -w_m2;
            3'b101, 3'b110: w_add = -w_m1;
            default:        w_add = '0;
        endcase
        w_sum    = {r_a[E-1], r_a} + w_add;
        w_a_nxt  = {w_sum[E], w_sum[E:2]};
        w_q_nxt  = {w_sum[1:0], r_q[E-1:2]};
        w_q1_nxt = r_q[1];
    end
`else
    logic [E-1:0] w_add;
    logic [E-1:0] w_sum;

    // Radix-2 step: add 0/+-M, then shift {A,Q,Q_1} right by 1.
    always_comb begin
        case ({r_q[0], r_q1})
            2'b01:   w_add = r_m;
            2'b10:   w_add = -r_m;
            default: w_add = '0;
        endcase
        w_sum    = r_a + w_add;
        w_a_nxt  = {w_sum[E-1], w_sum[E-1:1]};
        w_q_nxt  = {w_sum[0], r_q[E-1:1]};
        w_q1_nxt = r_q[0];
    end
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_last      = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == CW'(ITER - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, step while running, latch product on the last step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a   <= '0;
            r_q   <= '0;
            r_q1  <= 1'b0;
            r_m   <= '0;
            r_cnt <= '0;
            r_p   <= '0;
        end else if (w_load) begin
            r_a   <= '0;
            r_q   <= w_q_ext;
            r_q1  <= 1'b0;
            r_m   <= w_m_ext;
            r_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_a   <= w_a_nxt;
            r_q   <= w_q_nxt;
            r_q1  <= w_q1_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_p <= (2*WIDTH)'({w_a_nxt, w_q_nxt});
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.p    = r_p;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq (WIDTH=8): directed corner cases, back-to-back
// acceptance, asynchronous abort and a randomized sweep against an
// integer-arithmetic reference product.
module tb_booth_mult_seq;
    localparam int WIDTH = 8;
    localparam int E     = WIDTH + 2;
`ifdef BOOTH_RADIX4_EN
    localparam int ITER  = E / 2;
`else
    localparam int ITER  = E;
`endif
    localparam int NRAND = 1500;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    booth_mult_seq_if #(.WIDTH(WIDTH)) bus ();

    booth_mult_seq #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2*WIDTH-1:0] ref_prod(input logic sgn,
                                                    input logic [WIDTH-1:0] m,
                                                    input logic [WIDTH-1:0] q);
        longint a;
        longint b;
        if (sgn) begin
            a = longint'($signed(m));
            b = longint'($signed(q));
        end else begin
            a = longint'(m);
            b = longint'(q);
        end
        return (2*WIDTH)'(a * b);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] rand_operand();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 7))
            0: v = {1'b1, {(WIDTH-1){1'b0}}};
            1: v = {1'b0, {(WIDTH-1){1'b1}}};
            2: v = '1;
            3: v = '0;
            default: v = WIDTH'($urandom);
        endcase
        return v;
    endfunction

    // Issue one request from idle, check busy/hold during the run, latency, product, pulse width.
    task automatic do_op(input string tag, input logic sgn,
                         input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        int n;
        logic [2*WIDTH-1:0] p_old;
        p_old            = bus.p;
        bus.is_signed    = sgn;
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n <= ITER + 4) begin
            check({tag, "_busy"}, 64'(bus.busy), 64'd1);
            check({tag, "_hold"}, 64'(bus.p), 64'(p_old));
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(ITER + 1));
        check({tag, "_p"}, 64'(bus.p), 64'(ref_prod(sgn, m, q)));
        check({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
        tick();
        check({tag, "_done_width"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int n;
        int ndone;
        logic             sgn;
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] q;
        logic [2*WIDTH-1:0] exp_p;
        logic [2*WIDTH-1:0] p_old;

        bus.start        = 1'b0;
        bus.is_signed    = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;

        // Reset values.
        #3;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_p", 64'(bus.p), 64'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Small signed product.
        do_op("t1_7xm3", 1'b1, 8'd7, 8'hFD);
        check("t1_value", 64'(bus.p), 64'hFFEB);

        // Asynchronous reset three steps into a run.
        bus.is_signed = 1'b0; bus.multiplicand = 8'd100; bus.multiplier = 8'd50; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", 64'(bus.busy), 64'd0);
        check("t5_done", 64'(bus.done), 64'd0);
        check("t5_p", 64'(bus.p), 64'd0);
        #2 rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 2 * ITER; i++) begin
            tick();
            if (bus.done || bus.busy) ndone++;
        end
        check("t5_no_done_after_abort", 64'(ndone), 64'd0);
        do_op("t5_after", 1'b0, 8'd100, 8'd50);

        // Signed extremes.
        do_op("t2_min_min", 1'b1, 8'h80, 8'h80);
        check("t2_min_min_value", 64'(bus.p), 64'h4000);
        do_op("t2_min_max", 1'b1, 8'h80, 8'h7F);
        check("t2_min_max_value", 64'(bus.p), 64'hC080);

        // Unsigned extremes.
        do_op("t3_max_max", 1'b0, 8'hFF, 8'hFF);
        check("t3_max_max_value", 64'(bus.p), 64'hFE01);
        do_op("t3_zero", 1'b0, 8'h00, 8'd200);
        check("t3_zero_value", 64'(bus.p), 64'h0000);

        // start held high with churning operands during the run; accepted again in DONE.
        bus.is_signed = 1'b1; bus.multiplicand = 8'hFB; bus.multiplier = 8'h09; bus.start = 1'b1;
        tick();
        p_old = bus.p;
        n = 1;
        while (!bus.done && n <= ITER + 4) begin
            check("t4_busy", 64'(bus.busy), 64'd1);
            check("t4_hold", 64'(bus.p), 64'(p_old));
            bus.multiplicand = WIDTH'($urandom);
            bus.multiplier   = WIDTH'($urandom);
            bus.is_signed    = 1'($urandom);
            tick();
            n++;
        end
        check("t4_latency", 64'(n), 64'(ITER + 1));
        check("t4_p", 64'(bus.p), 64'hFFD3);
        bus.is_signed = 1'b0; bus.multiplicand = 8'd200; bus.multiplier = 8'd3;
        tick();
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n <= ITER + 4) begin
            check("t4b_busy", 64'(bus.busy), 64'd1);
            tick();
            n++;
        end
        check("t4b_latency", 64'(n), 64'(ITER + 1));
        check("t4b_p", 64'(bus.p), 64'h0258);
        tick();
        check("t4b_done_width", 64'(bus.done), 64'd0);

        // Randomized sweep, mixing back-to-back and idle-gap requests.
        sgn = 1'($urandom); m = rand_operand(); q = rand_operand();
        bus.is_signed = sgn; bus.multiplicand = m; bus.multiplier = q; bus.start = 1'b1;
        exp_p = ref_prod(sgn, m, q);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < NRAND; i++) begin
            n = 1;
            while (!bus.done && n <= ITER + 4) begin
                tick();
                n++;
            end
            check("rnd_latency", 64'(n), 64'(ITER + 1));
            check("rnd_p", 64'(bus.p), 64'(exp_p));
            if (i < NRAND - 1) begin
                if ($urandom_range(0, 1) == 1) begin
                    tick();
                    check("rnd_done_width", 64'(bus.done), 64'd0);
                end
                sgn = 1'($urandom); m = rand_operand(); q = rand_operand();
                bus.is_signed = sgn; bus.multiplicand = m; bus.multiplier = q; bus.start = 1'b1;
                exp_p = ref_prod(sgn, m, q);
                tick();
                bus.start = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
